// File: rtl/voice_mix_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// voice_mix_scheduler_pkg : mixer FSM encoding, sample limits and saturation.
// Revision: 1.0
// ============================================================================
package voice_mix_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COMMIT = 2'd2
  } mix_state_e;

  localparam int SAMPLE_W   = 16;
  localparam int SAMPLE_MAX = 32767;
  localparam int SAMPLE_MIN = -32768;

  // Callers sign-extend their accumulator to 32 bits before the clamp.
  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [31:0] value);
    if (value > SAMPLE_MAX) begin
      return SAMPLE_W'(SAMPLE_MAX);
    end else if (value < SAMPLE_MIN) begin
      return SAMPLE_W'(SAMPLE_MIN);
    end
    return value[SAMPLE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/voice_mix_scheduler_frame_sync.sv
`default_nettype none
// ============================================================================
// voice_mix_scheduler_frame_sync : 2-flop synchronizer and rising-edge detect.
// Revision: 1.0
// ============================================================================
module voice_mix_scheduler_frame_sync (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign frame_tick = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/voice_mix_scheduler.sv
`default_nettype none
// ============================================================================
// voice_mix_scheduler : per-frame voice fetch over a shared bus, saturating mix.
// Revision: 1.0
// ============================================================================
module voice_mix_scheduler
  import voice_mix_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_clk,
  input  logic [NUM_VOICES-1:0]      voice_enable,
  output logic                       voice_req,
  output logic [3:0]                 voice_sel,
  input  logic                       voice_valid,
  input  logic signed [SAMPLE_W-1:0] voice_left,
  input  logic signed [SAMPLE_W-1:0] voice_right,
  output logic signed [SAMPLE_W-1:0] sample_left,
  output logic signed [SAMPLE_W-1:0] sample_right,
  output logic                       sample_ready,
  output logic                       busy,
  output logic                       overrun,
  output logic                       timeout_err,
  input  logic                       clear_flags
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;

  logic frame_tick;

  voice_mix_scheduler_frame_sync u_frame_sync (
    .clk        (clk),
    .reset      (reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  mix_state_e                 state_q, state_d;
  logic [NUM_VOICES-1:0]      en_q, en_d;
  logic [3:0]                 idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [7:0]                 wait_q, wait_d;
  logic                       req_q, req_d;
  logic signed [SAMPLE_W-1:0] sample_l_q, sample_l_d, sample_r_q, sample_r_d;
  logic                       ready_q, ready_d;
  logic                       overrun_q, overrun_d, timeout_q, timeout_d;

  logic [3:0] first_idx, next_idx;
  logic       first_found, next_found, advance;

  // Lowest enabled voice at frame start, and lowest latched voice above idx.
  always_comb begin
    first_idx   = '0;
    first_found = 1'b0;
    next_idx    = '0;
    next_found  = 1'b0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (voice_enable[i]) begin
        first_idx   = 4'(i);
        first_found = 1'b1;
      end
      if (en_q[i] && (i > int'(idx_q))) begin
        next_idx   = 4'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    idx_d      = idx_q;
    acc_l_d    = acc_l_q;
    acc_r_d    = acc_r_q;
    wait_d     = wait_q;
    req_d      = req_q;
    sample_l_d = sample_l_q;
    sample_r_d = sample_r_q;
    ready_d    = 1'b0;
    overrun_d  = overrun_q & ~clear_flags;
    timeout_d  = timeout_q & ~clear_flags;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          en_d    = voice_enable;
          acc_l_d = '0;
          acc_r_d = '0;
          wait_d  = '0;
          idx_d   = first_idx;
          if (first_found) begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end else begin
            state_d = ST_COMMIT;
          end
        end
      end

      ST_FETCH: begin
        if (frame_tick) overrun_d = 1'b1;
        if (voice_valid && req_q) begin
          acc_l_d = acc_l_q + {{(ACC_W-SAMPLE_W){voice_left[SAMPLE_W-1]}}, voice_left};
          acc_r_d = acc_r_q + {{(ACC_W-SAMPLE_W){voice_right[SAMPLE_W-1]}}, voice_right};
          advance = 1'b1;
        end else if (wait_q == 8'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          advance   = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
        if (advance) begin
          wait_d = '0;
          if (next_found) begin
            idx_d = next_idx;
          end else begin
            state_d = ST_COMMIT;
            req_d   = 1'b0;
          end
        end
      end

      ST_COMMIT: begin
        if (frame_tick) overrun_d = 1'b1;
        sample_l_d = saturate({{(32-ACC_W){acc_l_q[ACC_W-1]}}, acc_l_q});
        sample_r_d = saturate({{(32-ACC_W){acc_r_q[ACC_W-1]}}, acc_r_q});
        ready_d    = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      en_q       <= '0;
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      wait_q     <= '0;
      req_q      <= 1'b0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      ready_q    <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      idx_q      <= idx_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      wait_q     <= wait_d;
      req_q      <= req_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      ready_q    <= ready_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign voice_req    = req_q;
  assign voice_sel    = idx_q;
  assign sample_left  = sample_l_q;
  assign sample_right = sample_r_q;
  assign sample_ready = ready_q;
  assign busy         = (state_q != ST_IDLE);
  assign overrun      = overrun_q;
  assign timeout_err  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_mix_scheduler.sv
`default_nettype none
// ============================================================================
// tb_voice_mix_scheduler : directed and random frames against a mix model.
// Revision: 1.0
// ============================================================================
module tb_voice_mix_scheduler;

  localparam int TMO = 15;

  logic               clk = 1'b0;
  logic               reset, frame_clk, clear_flags, voice_valid;
  logic [3:0]         voice_enable;
  logic signed [15:0] voice_left, voice_right;
  logic               voice_req, sample_ready, busy, overrun, timeout_err;
  logic [3:0]         voice_sel;
  logic signed [15:0] sample_left, sample_right;

  voice_mix_scheduler #(.NUM_VOICES(4), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_clk    (frame_clk),
    .voice_enable (voice_enable),
    .voice_req    (voice_req),
    .voice_sel    (voice_sel),
    .voice_valid  (voice_valid),
    .voice_left   (voice_left),
    .voice_right  (voice_right),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_ready (sample_ready),
    .busy         (busy),
    .overrun      (overrun),
    .timeout_err  (timeout_err),
    .clear_flags  (clear_flags)
  );

  initial forever #5 clk = ~clk;

  int                 total = 0;
  int                 bad = 0;
  int                 lat[16];
  logic signed [15:0] vl[16];
  logic signed [15:0] vr[16];
  int                 dwell[16];
  int                 sel_q[$];
  int                 ready_cnt = 0;
  int                 last_n;
  bit                 exp_to = 1'b0;
  bit                 exp_ov = 1'b0;
  logic               prev_req = 1'b0;
  logic [3:0]         prev_sel = 4'd0;
  int                 cnt = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic set_v(input int i, input int l, input int r, input int lt);
    vl[i]  = 16'(l);
    vr[i]  = 16'(r);
    lat[i] = lt;
  endtask

  // Voice bus responder: raises valid once a selected voice has waited lat cycles.
  initial begin
    voice_valid = 1'b0;
    voice_left  = '0;
    voice_right = '0;
    forever begin
      @(negedge clk);
      if (voice_req === 1'b1) begin
        if (!prev_req || voice_sel != prev_sel) begin
          cnt = 0;
          sel_q.push_back(int'(voice_sel));
        end else begin
          cnt++;
        end
        dwell[voice_sel] = cnt + 1;
        voice_valid = (cnt >= lat[voice_sel]);
        voice_left  = vl[voice_sel];
        voice_right = vr[voice_sel];
      end else begin
        voice_valid = 1'b0;
      end
      prev_req = (voice_req === 1'b1);
      prev_sel = voice_sel;
    end
  end

  initial forever begin
    @(negedge clk);
    if (sample_ready === 1'b1) ready_cnt++;
  end

  task automatic run_frame(input logic [3:0] en, input bit scramble, input int second_at,
                           input string tag);
    int sl, sr, n;
    int exp_sel[$];
    bit got;
    sl = 0;
    sr = 0;
    exp_sel = {};
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        exp_sel.push_back(i);
        if (lat[i] < TMO) begin
          sl += int'(vl[i]);
          sr += int'(vr[i]);
        end else begin
          exp_to = 1'b1;
        end
      end
    end
    if (second_at > 0) exp_ov = 1'b1;
    voice_enable = en;
    sel_q = {};
    ready_cnt = 0;
    frame_clk = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 300) begin
      tick();
      n++;
      if (n == 4) frame_clk = 1'b0;
      if (second_at > 0 && n == second_at) frame_clk = 1'b1;
      if (second_at > 0 && n == second_at + 4) frame_clk = 1'b0;
      if (scramble && n == 6) voice_enable = 4'($urandom);
      if (ready_cnt > 0) got = 1'b1;
    end
    frame_clk = 1'b0;
    last_n = n;
    check({tag, ".ready_seen"}, got, 1);
    repeat (10) tick();
    check({tag, ".ready_pulses"}, ready_cnt, 1);
    check({tag, ".busy_after"}, busy, 0);
    check({tag, ".left"}, sample_left, sat(sl));
    check({tag, ".right"}, sample_right, sat(sr));
    check({tag, ".timeout_err"}, timeout_err, exp_to);
    check({tag, ".overrun"}, overrun, exp_ov);
    check({tag, ".sel_count"}, sel_q.size(), exp_sel.size());
    for (int k = 0; k < exp_sel.size(); k++) begin
      if (k < sel_q.size()) check($sformatf("%s.sel%0d", tag, k), sel_q[k], exp_sel[k]);
    end
  endtask

  task automatic do_clear(input string tag);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    exp_to = 1'b0;
    exp_ov = 1'b0;
    tick();
    check({tag, ".timeout_clr"}, timeout_err, 0);
    check({tag, ".overrun_clr"}, overrun, 0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    frame_clk = 1'b0;
    clear_flags = 1'b0;
    voice_enable = '0;
    for (int i = 0; i < 16; i++) begin
      set_v(i, 0, 0, 0);
      dwell[i] = 0;
    end
    repeat (3) tick();
    check("rst.req", voice_req, 0);
    check("rst.sel", voice_sel, 0);
    check("rst.left", sample_left, 0);
    check("rst.right", sample_right, 0);
    check("rst.ready", sample_ready, 0);
    check("rst.busy", busy, 0);
    check("rst.overrun", overrun, 0);
    check("rst.timeout", timeout_err, 0);
    reset = 1'b1;
    repeat (3) tick();

    set_v(0, 100, 0, 2);
    set_v(1, -50, 0, 2);
    set_v(2, 1000, -1, 2);
    set_v(3, 7, 1, 2);
    run_frame(4'b1111, 1'b0, 0, "basic");

    for (int i = 0; i < 4; i++) set_v(i, 20000, -20000, 1);
    run_frame(4'b1111, 1'b0, 0, "sat");

    run_frame(4'b1010, 1'b0, 0, "sparse");

    run_frame(4'b0000, 1'b0, 0, "none");
    check("none.latency_le8", int'(last_n <= 8), 1);

    set_v(0, 300, -300, 0);
    set_v(1, 20, 40, 3);
    set_v(2, 5000, 5000, 255);
    set_v(3, -1, -2, 1);
    run_frame(4'b1111, 1'b0, 0, "tmo");
    check("tmo.dwell_v2", dwell[2], TMO);
    do_clear("tmo");

    for (int i = 0; i < 4; i++) set_v(i, 111 * (i + 1), -7 * (i + 1), 10);
    run_frame(4'b1111, 1'b0, 12, "ovr");
    do_clear("ovr");

    voice_enable = 4'b1111;
    frame_clk = 1'b1;
    n = 0;
    while (voice_req !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("rmf.req_seen", voice_req, 1);
    frame_clk = 1'b0;
    repeat (3) tick();
    #1 reset = 1'b0;
    #1;
    check("rmf.req", voice_req, 0);
    check("rmf.busy", busy, 0);
    check("rmf.left", sample_left, 0);
    check("rmf.right", sample_right, 0);
    check("rmf.ready", sample_ready, 0);
    ready_cnt = 0;
    exp_to = 1'b0;
    exp_ov = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (10) tick();
    check("rmf.no_ready", ready_cnt, 0);
    for (int i = 0; i < 4; i++) set_v(i, 1000 - 333 * i, 77 * i, 2);
    run_frame(4'b1111, 1'b0, 0, "rmf.after");

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 4; i++) begin
        set_v(i, int'($urandom_range(40000)) - 20000, int'($urandom_range(40000)) - 20000,
              int'($urandom_range(16)));
      end
      run_frame(4'($urandom), 1'b1, 0, $sformatf("rnd%0d", it));
      if (exp_to) do_clear($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/voice_mix_scheduler.md
Name: voice_mix_scheduler

Overview:
- Sequences the per-frame sample fetch from NUM_VOICES voice generators.
- Arbitrates the single shared voice-read bus in fixed index order. Sums the signed left/right samples with saturation.
- Presents a stable stereo pair to the I2S serializer's sample_left/sample_right inputs.
- Triggered once per audio frame by the serializer's frame clock.

Parameters:
- NUM_VOICES, 4: number of voice generators on the shared read bus (1..16).
- TIMEOUT, 15: max cycles to wait for voice_valid before substituting 0 (1..255).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- frame_clk  input  1  frame clock from I2S serializer; asynchronous to clk; 2-flop synchronized internally.
- voice_enable  input  NUM_VOICES  per-voice mix enable; sampled at frame start.
- voice_req  output  1  read request on shared voice bus.
- voice_sel  output  4  index of voice being read.
- voice_valid  input  1  requested voice's data valid this cycle.
- voice_left  input  16  signed left sample of selected voice.
- voice_right  input  16  signed right sample of selected voice.
- sample_left  output  16  signed mixed left; held between commits.
- sample_right  output  16  signed mixed right; held between commits.
- sample_ready  output  1  one-cycle pulse when new mix is committed.
- busy  output  1  high while not IDLE.
- overrun  output  1  sticky: frame edge arrived while busy.
- timeout_err  output  1  sticky: a voice timed out.
- clear_flags  input  1  synchronous clear of overrun and timeout_err.

Behaviour:
- Reset (reset==0), all outputs 0:
  - voice_req, voice_sel, sample_left, sample_right, sample_ready, busy, overrun, timeout_err all 0.
  - State IDLE. Synchronizer and edge-detect flops 0.
- Frame start:
  - frame_clk passes through 2 flops, then a rising-edge detect, giving frame_tick.
  - frame_tick occurs 3 clk after the async edge, worst case.
- FSM states: IDLE, FETCH, COMMIT.
- IDLE, on frame_tick:
  - Latch voice_enable to en_q. Clear accumulators acc_l/acc_r.
  - Set idx to the lowest enabled index.
  - If none enabled, go straight to COMMIT (mix = 0).
- FETCH:
  - voice_req=1 and voice_sel=idx, both registered.
  - Wait counter counts cycles with voice_req high and voice_valid low.
  - voice_valid ignored while voice_req=0.
  - On voice_valid: add sign-extended voice_left/voice_right to acc_l/acc_r. Advance idx to the next enabled index above idx.
  - If no enabled index remains above idx, go to COMMIT. voice_req drops in the same cycle.
  - Minimum 1 cycle per enabled voice. Back-to-back valids are allowed. A voice may respond with valid the cycle after req rises.
  - Timeout: TIMEOUT consecutive cycles without valid sets timeout_err. That voice contributes 0 and idx advances.
- COMMIT (1 cycle):
  - sample_left/right <= saturate(acc) to the range [-32768, 32767].
  - sample_ready=1 this cycle. Return to IDLE.
- Accumulator: signed, 16+ceil(log2(NUM_VOICES))+1 bits; no internal overflow possible.
- Disabled voices: never selected; consume no cycles.
- Overrun:
  - frame_tick in FETCH or COMMIT sets overrun. The tick is dropped.
  - The in-progress mix completes normally.
  - frame_tick in the same cycle COMMIT exits is also an overrun. The next frame is taken on the following tick.
- Flags: clear_flags and a simultaneous set in the same cycle leaves the flag set (set wins).
- voice_enable changes mid-frame have no effect until the next frame.
- Reset asserted mid-FETCH: voice_req drops asynchronously. No partial mix is committed.
- busy = (state != IDLE).

Decomposition:
- Shared audio package holds:
  - FSM state encoding (IDLE/FETCH/COMMIT).
  - SAMPLE_W=16 and the SAMPLE_MAX/SAMPLE_MIN saturation constants.
  - A saturate function, shared with future mixers.
- One natural sub-module, frame_sync: 2-flop synchronizer plus rising-edge detector for frame_clk, output frame_tick.
- Next-enabled-index search (priority encoder over en_q masked above idx) stays inline.

Test Plan:
- Four voices enabled, each answering valid 2 cycles after req, with L = {100, -50, 1000, 7} and R = {0, 0, -1, 1}:
  - sample_left=1057, sample_right=0.
  - Exactly one sample_ready pulse. busy low afterwards.
- Four voices at 20000 left and four at -20000 right:
  - sample_left=32767, sample_right=-32768 (saturation both directions).
- voice_enable=4'b1010:
  - Only voice_sel=1 then 3 appear on the bus.
  - voice_enable=0 gives sample_ready within 5 clk of frame_tick, with both outputs 0.
- Voice 2 never asserts valid, TIMEOUT=15:
  - idx advances after 15 cycles and timeout_err=1.
  - Mix excludes voice 2. clear_flags returns timeout_err to 0.
- Second frame_clk edge while in FETCH:
  - overrun=1. Current mix commits once; no second fetch sequence.
- reset pulled low mid-FETCH:
  - All outputs 0 immediately, with no sample_ready.
  - After release, the next frame mixes correctly.
